debounce_multi: RTL and testbench
=================================

# debounce_multi

Parameterised N-channel push-button debouncer. It is the successor to the single-channel debouncer and adds a configurable input synchroniser, a configurable stability window, one-cycle rise/fall event pulses and optional long-press detection per channel. It sits between raw board buttons/switches and the control FSMs that consume clean levels and edge events.

## Interface
- `N_CH`, default 4: number of independent channels.
- `STABLE_CYCLES`, default 16: consecutive sampled cycles the synchronised input must differ from `level` before `level` toggles. Must be ≥ 2.
- `SYNC_STAGES`, default 2: flop stages in the per-channel input synchroniser. Must be ≥ 2.
- `LONG_CYCLES`, default 256: hold time in cycles for a long-press event. Must be > `STABLE_CYCLES`. Used only with `DEBOUNCE_LONGPRESS_EN`.

Ports:
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, synchronous, active-high.
- `btn`, input, N_CH: raw asynchronous button inputs.
- `level`, output, N_CH: debounced level per channel.
- `rise`, output, N_CH: one-cycle pulse coincident with `level` going 0→1.
- `fall`, output, N_CH: one-cycle pulse coincident with `level` going 1→0.
- `long_press`, output, N_CH: one-cycle pulse when a press has been held `LONG_CYCLES` cycles.

## Operation
- Channels are fully independent. There is no shared state between channels except `clk` and `rst`.
- Each channel passes through a `SYNC_STAGES`-deep synchroniser, then a 4-state FSM:
  - `IDLE_LO`: `level` = 0. If the sync output is 1, go to `WAIT_HI` with cnt = 1.
  - `WAIT_HI`: if sync = 1 and cnt = `STABLE_CYCLES`−1, go to `IDLE_HI`, register `level` = 1 and pulse `rise`. If sync = 1 otherwise, cnt++. If sync = 0, go back to `IDLE_LO` with cnt = 0 (bounce rejected).
  - `IDLE_HI` and `WAIT_LO`: mirror image of the two states above, using `fall`.
- The stability counter width is $clog2(`STABLE_CYCLES`+1). It never wraps; it clears on every bounce.
- `rise`, `fall` and `long_press` are registered. They are high for exactly one cycle per event. `rise` and `fall` are never both high on one channel.
- Reset: all synchroniser flops, counters, `level`, `rise`, `fall` and `long_press` are 0, and every FSM is in `IDLE_LO`. Asserting `rst` mid-`WAIT_*` discards the count, and no event is emitted.

## Timing
- `btn` changes between edges, and the first edge that samples the new value is edge 1. `level`, `rise` and `fall` update at edge `SYNC_STAGES`+`STABLE_CYCLES` (edge 18 with defaults).
- Any glitch shorter than `STABLE_CYCLES` sampled cycles at the synchroniser output produces no output change.
- Each bounce restarts the full window. Latency is therefore measured from the last transition.
- After reset is released with `btn` held high, `rise` occurs at edge `SYNC_STAGES`+`STABLE_CYCLES` after the first non-reset edge.

## Configuration
- Macro: `DEBOUNCE_LONGPRESS_EN`.
- Defined:
  - Each channel has a hold counter of width $clog2(`LONG_CYCLES`+1).
  - The counter clears on the `rise` cycle and increments every cycle in `IDLE_HI`/`WAIT_LO`, saturating at `LONG_CYCLES`.
  - `long_press` pulses once, on the cycle the counter reaches `LONG_CYCLES`. The earliest pulse is `LONG_CYCLES` cycles after `rise`.
  - Releasing the button before that point produces no pulse. At most one pulse is produced per press.
  - Entering `WAIT_LO` does not clear the hold counter. A bounce back to `IDLE_HI` continues the count.
- Undefined: no hold counters are built, `long_press` is tied to 0, and `LONG_CYCLES` is unused.

## Structure
- Package `debounce_pkg` holds:
  - the state typedef `db_state_t` (`IDLE_LO`, `WAIT_HI`, `IDLE_HI`, `WAIT_LO`);
  - a width helper function for the counters.
- Sub-module `debounce_channel` contains the synchroniser, FSM and optional hold counter for one channel. `debounce_multi` instantiates it `N_CH` times with a generate loop.
- The FSM state is visible as `state` inside `debounce_channel` for bench probing.

## Test plan
Parameters for all scenarios: `N_CH`=4, `STABLE_CYCLES`=16, `SYNC_STAGES`=2, `LONG_CYCLES`=64.
- **Reset:** hold `rst` 3 cycles with `btn`=4'hF → all outputs 0 during reset. After release, `rise`=4'hF for one cycle and `level`=4'hF at edge 18.
- **Bounce rejection:** on ch0 drive 1 for 5 cycles, 0 for 3, 1 for 10, then 0 → no `level`/`rise` change. Then drive 1 and hold → `rise[0]` exactly 18 edges after the final 0→1.
- **Independence:** press ch1 and ch2 together and ch3 4 cycles later → `rise[1]` and `rise[2]` in the same cycle, `rise[3]` 4 cycles after. ch0 stays unchanged.
- **Bouncy release:** after a stable press, on ch2 drive 0 for 4 cycles, 1 for 2, then 0 sustained → a single `fall[2]` 18 edges after the last 1→0, and no spurious `rise`.
- **Long press (macro defined):** hold ch0 for 100 cycles after `rise` → one `long_press[0]` pulse 64 cycles after `rise`. Release at 50 cycles → no pulse. With the macro undefined, `long_press` stays 0.
- **Reset mid-wait:** assert `rst` when the ch1 count is 10 → counters clear, `level[1]` stays 0, and no `rise` pulse appears.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel push-button debouncer.
package debounce_pkg;

    // Per-channel debounce FSM states.
    typedef enum logic [1:0] {
        IDLE_LO,
        WAIT_HI,
        IDLE_HI,
        WAIT_LO
    } db_state_t;

    // Bits needed to hold a counter value in the range 0..max_count.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: input synchroniser, 4-state stability FSM with
// registered rise/fall pulses and, when DEBOUNCE_LONGPRESS_EN is defined,
// a saturating hold counter that emits a single long_press pulse per press.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned LONG_CYCLES   = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise,
    output logic fall,
    output logic long_press
);

    localparam int unsigned         CNT_W    = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);

    // Reject configurations the FSM and hold counter cannot honour.
    if (STABLE_CYCLES < 2 || SYNC_STAGES < 2 || LONG_CYCLES <= STABLE_CYCLES) begin : g_bad_params
        $error("debounce_channel: need STABLE_CYCLES>=2, SYNC_STAGES>=2, LONG_CYCLES>STABLE_CYCLES");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    db_state_t              state;
    logic [CNT_W-1:0]       cnt;
    logic                   rise_now;

    assign sync     = sync_q[SYNC_STAGES-1];
    assign rise_now = (state == WAIT_HI) && sync && (cnt == CNT_LAST);

    // Shift the raw button through the synchroniser chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
        end
    end

    // Stability FSM: a level change needs STABLE_CYCLES consecutive samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE_LO;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                IDLE_LO: begin
                    if (sync) begin
                        state <= WAIT_HI;
                        cnt   <= CNT_ONE;
                    end
                end
                WAIT_HI: begin
                    if (!sync) begin
                        state <= IDLE_LO;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE_HI;
                        cnt   <= '0;
                        level <= 1'b1;
                        rise  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                IDLE_HI: begin
                    if (!sync) begin
                        state <= WAIT_LO;
                        cnt   <= CNT_ONE;
                    end
                end
                WAIT_LO: begin
                    if (sync) begin
                        state <= IDLE_HI;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE_LO;
                        cnt   <= '0;
                        level <= 1'b0;
                        fall  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE_LO;
                    cnt   <= '0;
                    level <= 1'b0;
                end
            endcase
        end
    end

`ifdef DEBOUNCE_LONGPRESS_EN
    localparam int unsigned      HOLD_W    = cnt_width(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_CYCLES - 1);

    logic [HOLD_W-1:0] hold_cnt;

    // Hold counter: cleared on rise, counts while high (bounces included), saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt   <= '0;
            long_press <= 1'b0;
        end else begin
            long_press <= 1'b0;
            if (rise_now) begin
                hold_cnt <= '0;
            end else if ((state == IDLE_HI || state == WAIT_LO) && hold_cnt != HOLD_LAST) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
                if (hold_cnt == HOLD_PRE) begin
                    long_press <= 1'b1;
                end
            end
        end
    end
`else
    logic unused_rise_now;
    assign unused_rise_now = rise_now;

    // Long-press detection not built.
    assign long_press = 1'b0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// N-channel push-button debouncer: one independent debounce_channel per
// button. Optional long-press detection is enabled by DEBOUNCE_LONGPRESS_EN.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int unsigned N_CH          = 4,
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned LONG_CYCLES   = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] long_press
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .SYNC_STAGES   (SYNC_STAGES),
            .LONG_CYCLES   (LONG_CYCLES)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .btn        (btn[i]),
            .level      (level[i]),
            .rise       (rise[i]),
            .fall       (fall[i]),
            .long_press (long_press[i])
        );
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed self-checking bench for debounce_multi (N_CH=4, STABLE_CYCLES=16,
// SYNC_STAGES=2, LONG_CYCLES=64).
module tb_debounce_multi;
    import debounce_pkg::*;

`ifdef DEBOUNCE_LONGPRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] btn;
    logic [3:0] level;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] long_press;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    debounce_multi #(
        .N_CH          (4),
        .STABLE_CYCLES (16),
        .SYNC_STAGES   (2),
        .LONG_CYCLES   (64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn),
        .level      (level),
        .rise       (rise),
        .fall       (fall),
        .long_press (long_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then compare every output.
    task automatic cycle(input logic [3:0] lvl, input logic [3:0] r, input logic [3:0] f,
                         input logic [3:0] lp, input string tag);
        @(posedge clk);
        #1;
        chk({tag, ".level"}, level, lvl);
        chk({tag, ".rise"}, rise, r);
        chk({tag, ".fall"}, fall, f);
        chk({tag, ".long_press"}, long_press, lp);
    endtask

    // n quiet cycles: level steady, no events.
    task automatic run(input int n, input logic [3:0] lvl, input string tag);
        for (int i = 0; i < n; i++) cycle(lvl, 4'h0, 4'h0, 4'h0, tag);
    endtask

    initial begin
        logic [3:0] lp_exp;
        rst = 1'b1;
        btn = 4'hF;

        // Reset with all buttons pressed: outputs held at 0.
        run(3, 4'h0, "reset_hold");
        rst = 1'b0;
        run(17, 4'h0, "reset_release_wait");
        cycle(4'hF, 4'hF, 4'h0, 4'h0, "reset_rise_edge18");
        run(1, 4'hF, "reset_after_rise");

        // Release all: fall 18 edges later.
        btn = 4'h0;
        run(17, 4'hF, "release_all_wait");
        cycle(4'h0, 4'h0, 4'hF, 4'h0, "release_all_fall");
        run(2, 4'h0, "release_all_idle");

        // Bounce rejection on ch0: 1x5, 0x3, 1x10, then 0.
        btn = 4'h1; run(5, 4'h0, "bounce_hi5");
        btn = 4'h0; run(3, 4'h0, "bounce_lo3");
        btn = 4'h1; run(10, 4'h0, "bounce_hi10");
        btn = 4'h0; run(20, 4'h0, "bounce_settle");
        btn = 4'h1;
        run(17, 4'h0, "bounce_final_wait");
        cycle(4'h1, 4'h1, 4'h0, 4'h0, "bounce_rise0");
        run(1, 4'h1, "bounce_after_rise");

        // Independence: ch1+ch2 together, ch3 four cycles later.
        btn = 4'h7;
        run(4, 4'h1, "indep_wait_a");
        btn = 4'hF;
        run(13, 4'h1, "indep_wait_b");
        cycle(4'h7, 4'h6, 4'h0, 4'h0, "indep_rise12");
        run(3, 4'h7, "indep_gap");
        cycle(4'hF, 4'h8, 4'h0, 4'h0, "indep_rise3");
        run(1, 4'hF, "indep_after");

        // Bouncy release on ch2: 0x4, 1x2, then 0 sustained.
        btn = 4'hB; run(4, 4'hF, "brel_lo4");
        btn = 4'hF; run(2, 4'hF, "brel_hi2");
        btn = 4'hB;
        run(17, 4'hF, "brel_wait");
        cycle(4'hB, 4'h0, 4'h4, 4'h0, "brel_fall2");
        run(2, 4'hB, "brel_after");

        // Clean slate before long-press checks.
        rst = 1'b1;
        btn = 4'h0;
        run(2, 4'h0, "reset2_hold");
        rst = 1'b0;
        run(2, 4'h0, "reset2_idle");

        // Long press on ch0: hold 100 cycles after rise.
        btn = 4'h1;
        run(17, 4'h0, "long_wait");
        cycle(4'h1, 4'h1, 4'h0, 4'h0, "long_rise");
        for (int k = 1; k <= 100; k++) begin
            lp_exp = (LP_EN && k == 64) ? 4'h1 : 4'h0;
            cycle(4'h1, 4'h0, 4'h0, lp_exp, "long_hold");
        end
        btn = 4'h0;
        run(17, 4'h1, "long_release_wait");
        cycle(4'h0, 4'h0, 4'h1, 4'h0, "long_fall");
        run(2, 4'h0, "long_idle");

        // Short press: level drops 50 cycles after rise, no long_press.
        btn = 4'h1;
        run(17, 4'h0, "short_wait");
        cycle(4'h1, 4'h1, 4'h0, 4'h0, "short_rise");
        run(32, 4'h1, "short_hold");
        btn = 4'h0;
        run(17, 4'h1, "short_release_wait");
        cycle(4'h0, 4'h0, 4'h1, 4'h0, "short_fall");
        run(30, 4'h0, "short_idle");

        // Reset mid-wait on ch1 at count 10.
        btn = 4'h2;
        run(12, 4'h0, "midwait_count");
        n_checks++;
        assert (dut.g_ch[1].u_ch.state === WAIT_HI) else begin
            n_fail++;
            $error("FAIL midwait_state: observed %0d expected %0d", dut.g_ch[1].u_ch.state, WAIT_HI);
        end
        n_checks++;
        assert (dut.g_ch[1].u_ch.cnt === 5'd10) else begin
            n_fail++;
            $error("FAIL midwait_cnt: observed %0d expected 10", dut.g_ch[1].u_ch.cnt);
        end
        rst = 1'b1;
        run(2, 4'h0, "midwait_rst");
        n_checks++;
        assert (dut.g_ch[1].u_ch.state === IDLE_LO) else begin
            n_fail++;
            $error("FAIL midwait_state_clr: observed %0d expected %0d", dut.g_ch[1].u_ch.state, IDLE_LO);
        end
        n_checks++;
        assert (dut.g_ch[1].u_ch.cnt === 5'd0) else begin
            n_fail++;
            $error("FAIL midwait_cnt_clr: observed %0d expected 0", dut.g_ch[1].u_ch.cnt);
        end
        rst = 1'b0;
        btn = 4'h0;
        run(25, 4'h0, "midwait_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
